// File: rtl/ch_est_packer.sv
// rtl/ch_est_packer.sv - groups serial per-RE channel estimates into pair/triple words
//
// Purpose: buffers one I/Q estimate per valid cycle and emits complete groups of
// 2 (pairs) or 3 (triples) as a single-cycle pulse in averager slot order.
// At symbol end a partial group is flushed, padded by replicating the last sample.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   i_in, q_in          signed I/Q estimate, qualified by in_vld
//   parallel_mode       bit0: 1 = triples, 0 = pairs; bit1 ignored
//   sym_end             last sample of symbol; flush partial group
//   sym_abort           drop partial group and same-cycle sample, clear group index
//   i_packed, q_packed  slot A [3W-1:2W], slot B [2W-1:W], slot C [W-1:0]
//   out_vld             one-cycle pulse, packed words valid
//   grp_idx             index of the emitted group within the symbol
//   padded              group completed by replication
module ch_est_packer #(
    parameter int DATA_WIDTH    = 16,
    parameter int GRP_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  i_in,
    input  logic signed [DATA_WIDTH-1:0]  q_in,
    input  logic                          in_vld,
    input  logic [1:0]                    parallel_mode,
    input  logic                          sym_end,
    input  logic                          sym_abort,
    output logic [3*DATA_WIDTH-1:0]       i_packed,
    output logic [3*DATA_WIDTH-1:0]       q_packed,
    output logic                          out_vld,
    output logic [GRP_CNT_WIDTH-1:0]      grp_idx,
    output logic                          padded
);

    typedef enum logic {S_EMPTY, S_FILL} state_t;

    state_t                     r_state;
    logic [1:0]                 r_cnt;
    logic                       r_mode;
    logic [DATA_WIDTH-1:0]      r_i_a, r_i_b, r_q_a, r_q_b;
    logic [GRP_CNT_WIDTH-1:0]   r_grp_cnt;
    logic [3*DATA_WIDTH-1:0]    r_i_packed, r_q_packed;
    logic                       r_out_vld;
    logic [GRP_CNT_WIDTH-1:0]   r_grp_idx;
    logic                       r_padded;

    state_t                     w_state_nxt;
    logic [1:0]                 w_cnt_nxt;
    logic [1:0]                 w_cnt_inc;
    logic                       w_mode;
    logic                       w_full;
    logic                       w_flush;
    logic                       w_emit;
    logic [DATA_WIDTH-1:0]      w_i_a, w_i_b, w_i_c, w_q_a, w_q_b, w_q_c;
    logic                       w_unused_mode;

    assign w_unused_mode = parallel_mode[1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        // Mode is taken live on the first sample of a group, then held.
        w_mode      = (r_state == S_EMPTY) ? parallel_mode[0] : r_mode;
        w_cnt_inc   = r_cnt + {1'b0, in_vld};
        w_full      = in_vld && (w_cnt_inc == (w_mode ? 2'd3 : 2'd2));
        w_flush     = sym_end && (w_cnt_inc != 2'd0) && !w_full;
        w_emit      = !sym_abort && (w_full || w_flush);

        // Each slot takes either its stored sample, the same-cycle sample, or a
        // copy of the previous slot; the copy is what implements replication
        // padding, so padded slots can never show stale buffer contents.
        w_i_a = (r_cnt == 2'd0) ? i_in : r_i_a;
        w_q_a = (r_cnt == 2'd0) ? q_in : r_q_a;
        if (r_cnt == 2'd2) begin
            w_i_b = r_i_b;
            w_q_b = r_q_b;
        end else if (r_cnt == 2'd1 && in_vld) begin
            w_i_b = i_in;
            w_q_b = q_in;
        end else begin
            w_i_b = w_i_a;
            w_q_b = w_q_a;
        end
        if (!w_mode) begin
            w_i_c = '0;
            w_q_c = '0;
        end else if (r_cnt == 2'd2 && in_vld) begin
            w_i_c = i_in;
            w_q_c = q_in;
        end else begin
            w_i_c = w_i_b;
            w_q_c = w_q_b;
        end

        if (sym_abort || w_emit) begin
            w_state_nxt = S_EMPTY;
            w_cnt_nxt   = 2'd0;
        end else if (in_vld) begin
            w_state_nxt = S_FILL;
            w_cnt_nxt   = w_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Sample storage is deliberately not reset or cleared between groups.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= 1'b0;
            r_i_a  <= '0;
            r_i_b  <= '0;
            r_q_a  <= '0;
            r_q_b  <= '0;
        end else if (in_vld && !sym_abort) begin
            if (r_state == S_EMPTY) begin
                r_mode <= parallel_mode[0];
            end
            if (r_cnt == 2'd0) begin
                r_i_a <= i_in;
                r_q_a <= q_in;
            end else if (r_cnt == 2'd1) begin
                r_i_b <= i_in;
                r_q_b <= q_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_packed <= '0;
            r_q_packed <= '0;
            r_out_vld  <= 1'b0;
            r_padded   <= 1'b0;
            r_grp_idx  <= '0;
            r_grp_cnt  <= '0;
        end else begin
            r_out_vld <= w_emit;
            if (w_emit) begin
                r_i_packed <= {w_i_a, w_i_b, w_i_c};
                r_q_packed <= {w_q_a, w_q_b, w_q_c};
                r_padded   <= w_flush;
                r_grp_idx  <= r_grp_cnt;
            end else if (sym_end || sym_abort) begin
                r_grp_idx  <= '0;
            end
            // The running index restarts with every symbol boundary, even when
            // the boundary itself emits a group.
            if (sym_end || sym_abort) begin
                r_grp_cnt <= '0;
            end else if (w_emit) begin
                r_grp_cnt <= r_grp_cnt + 1'b1;
            end
        end
    end

    assign i_packed = r_i_packed;
    assign q_packed = r_q_packed;
    assign out_vld  = r_out_vld;
    assign grp_idx  = r_grp_idx;
    assign padded   = r_padded;

endmodule

// File: tb/tb_ch_est_packer.sv
// tb/tb_ch_est_packer.sv - scoreboard testbench for ch_est_packer
`timescale 1ns/1ps
module tb_ch_est_packer;

    localparam int DW = 16;
    localparam int GW = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic signed [DW-1:0]   i_in = '0;
    logic signed [DW-1:0]   q_in = '0;
    logic                   in_vld = 1'b0;
    logic [1:0]             parallel_mode = 2'b00;
    logic                   sym_end = 1'b0;
    logic                   sym_abort = 1'b0;
    logic [3*DW-1:0]        i_packed, q_packed;
    logic                   out_vld;
    logic [GW-1:0]          grp_idx;
    logic                   padded;

    ch_est_packer #(.DATA_WIDTH(DW), .GRP_CNT_WIDTH(GW)) dut (
        .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .in_vld(in_vld),
        .parallel_mode(parallel_mode), .sym_end(sym_end), .sym_abort(sym_abort),
        .i_packed(i_packed), .q_packed(q_packed), .out_vld(out_vld),
        .grp_idx(grp_idx), .padded(padded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3*DW-1:0] ip;
        logic [3*DW-1:0] qp;
        logic [GW-1:0]   grp;
        logic            pad;
        int              due;
    } exp_t;

    exp_t            sb[$];
    logic [DW-1:0]   m_i[$];
    logic [DW-1:0]   m_q[$];
    logic            m_mode = 1'b0;
    int              m_grp = 0;
    int              edge_cnt = 0;
    int              n_chk = 0;
    int              n_fail = 0;
    logic [3*DW-1:0] last_i = '0;
    logic [3*DW-1:0] last_q = '0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_emit(input logic pad);
        exp_t e;
        e.ip  = {m_i[0], m_i[1], (m_mode ? m_i[2] : 16'd0)};
        e.qp  = {m_q[0], m_q[1], (m_mode ? m_q[2] : 16'd0)};
        e.grp = m_grp[GW-1:0];
        e.pad = pad;
        e.due = edge_cnt + 1;
        sb.push_back(e);
        m_grp = (m_grp + 1) % 256;
        m_i.delete();
        m_q.delete();
    endtask

    task automatic drive(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q,
                         input logic v, input logic [1:0] m, input logic se, input logic ab);
        int n;
        i_in = i; q_in = q; in_vld = v; parallel_mode = m; sym_end = se; sym_abort = ab;
        if (ab) begin
            m_i.delete();
            m_q.delete();
            m_grp = 0;
        end else begin
            if (v) begin
                if (m_i.size() == 0) m_mode = m[0];
                m_i.push_back(i);
                m_q.push_back(q);
            end
            n = m_mode ? 3 : 2;
            if (m_i.size() == n) begin
                model_emit(1'b0);
            end else if (se && m_i.size() > 0) begin
                while (m_i.size() < n) begin
                    m_i.push_back(m_i[m_i.size()-1]);
                    m_q.push_back(m_q[m_q.size()-1]);
                end
                model_emit(1'b1);
            end
            if (se) m_grp = 0;
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0; sym_end = 1'b0; sym_abort = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 1'b0, parallel_mode, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last_i = '0;
            last_q = '0;
        end else begin
            if (sb.size() > 0 && sb[0].due < edge_cnt) begin
                e = sb.pop_front();
                check("missing_vld", 64'd0, 64'd1);
            end
            if (out_vld) begin
                if (sb.size() == 0) begin
                    check("unexpected_vld", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", edge_cnt, e.due);
                    check("i_packed", i_packed, e.ip);
                    check("q_packed", q_packed, e.qp);
                    check("grp_idx", grp_idx, e.grp);
                    check("padded", padded, e.pad);
                end
                last_i = i_packed;
                last_q = q_packed;
            end else begin
                check("hold_i", i_packed, last_i);
                check("hold_q", q_packed, last_q);
            end
        end
    end

    initial begin
        #2 rst = 1'b0;
        #1;
        check("rst_vld", out_vld, 0);
        check("rst_pad", padded, 0);
        check("rst_i", i_packed, 0);
        check("rst_q", q_packed, 0);
        check("rst_grp", grp_idx, 0);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;

        // triples 3,6,9
        drive(3, -3, 1, 2'b01, 0, 0);
        drive(6, -6, 1, 2'b01, 0, 0);
        drive(9, -9, 1, 2'b01, 0, 0);
        idle(1);
        check("t1_i_const", i_packed, 48'h0003_0006_0009);
        drive(0, 0, 0, 2'b01, 1, 0);

        // pairs -5,7,-1,4 then an empty sym_end
        drive(-5, 1, 1, 2'b00, 0, 0);
        drive(7, 2, 1, 2'b00, 0, 0);
        drive(-1, 3, 1, 2'b00, 0, 0);
        drive(4, 4, 1, 2'b00, 0, 0);
        idle(1);
        check("t2_grp_before", grp_idx, 1);
        drive(0, 0, 0, 2'b00, 1, 0);
        check("t2_grp_clr", grp_idx, 0);

        // triples flush with two samples
        drive(10, 100, 1, 2'b01, 0, 0);
        drive(20, 200, 1, 2'b01, 1, 0);
        idle(1);
        check("t3_i_const", i_packed, 48'h000a_0014_0014);
        check("t3_pad_const", padded, 1);
        drive(1, 1, 1, 2'b01, 0, 0);
        drive(2, 2, 1, 2'b01, 0, 0);
        drive(3, 3, 1, 2'b01, 0, 0);

        // other flush shapes: triples one sample, pairs one sample
        drive(5, 6, 1, 2'b01, 1, 0);
        drive(8, 9, 0, 2'b00, 0, 0);
        drive(8, 9, 1, 2'b00, 1, 0);
        idle(1);
        check("pair_flush_const", i_packed, 48'h0008_0008_0000);

        // mode switch mid-group
        drive(1, 11, 1, 2'b01, 0, 0);
        drive(2, 12, 1, 2'b00, 0, 0);
        drive(3, 13, 1, 2'b10, 0, 0);
        drive(4, 14, 1, 2'b00, 0, 0);
        drive(5, 15, 1, 2'b00, 0, 0);
        idle(1);
        check("t4_i_const", i_packed, 48'h0004_0005_0000);
        drive(0, 0, 0, 2'b00, 1, 0);

        // abort with second sample
        drive(1, 1, 1, 2'b01, 0, 0);
        drive(2, 2, 1, 2'b01, 0, 1);
        drive(7, 7, 1, 2'b01, 0, 0);
        drive(8, 8, 1, 2'b01, 0, 0);
        drive(9, 9, 1, 2'b01, 0, 0);
        idle(1);
        check("t5_i_const", i_packed, 48'h0007_0008_0009);
        check("t5_grp_const", grp_idx, 0);

        // async reset mid-group with gaps
        drive(21, 1, 1, 2'b01, 0, 0);
        idle(2);
        drive(22, 2, 1, 2'b01, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_vld", out_vld, 0);
        check("arst_i", i_packed, 0);
        check("arst_q", q_packed, 0);
        check("arst_grp", grp_idx, 0);
        m_i.delete(); m_q.delete(); m_grp = 0;
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        drive(11, 31, 1, 2'b01, 0, 0);
        idle(1);
        drive(12, 32, 1, 2'b01, 0, 0);
        idle(2);
        drive(13, 33, 1, 2'b01, 0, 0);
        idle(1);
        check("arst_slot_a", i_packed, 48'h000b_000c_000d);
        drive(0, 0, 0, 2'b01, 1, 0);

        // long pair stream to wrap grp_idx
        for (int k = 0; k < 600; k++)
            drive($urandom_range(0, 65535), $urandom_range(0, 65535), 1, 2'b00, 0, 0);
        drive(0, 0, 0, 2'b00, 1, 0);

        // random mix
        for (int k = 0; k < 1500; k++)
            drive($urandom_range(0, 65535), $urandom_range(0, 65535),
                  ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 49) == 0));

        idle(4);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
